// File: rtl/amdc_gpio_arb_pkg.sv
// Shared types and default widths for the GPIO direct-bank register arbiter.
package amdc_gpio_arb_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/amdc_rr_arb2.sv
// Two-way round-robin grant selector with a one-hot grant and a single
// pointer bit recording which port wins the next tie.
module amdc_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic favour_one;

  // A lone requester always wins; only a tie consults the pointer.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = favour_one ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      favour_one <= 1'b0;
    end else if (advance && (|req)) begin
      favour_one <= grant[0];
    end
  end

endmodule

// File: rtl/amdc_gpio_reg_arbiter.sv
// Arbitrates the AXI-side requester and the internal sequencer onto the
// single-ported GPIO direct register bank, one transaction at a time.
module amdc_gpio_reg_arbiter
  import amdc_gpio_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  input  logic [DATA_WIDTH-1:0]   reg_rdata
);

  arb_state_e state, state_next;

  logic [1:0]            grant;
  logic                  grant_idx;
  logic                  arb_take;
  logic                  cur_port;
  logic                  cur_write;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] cap_data;

  assign arb_take  = (state == IDLE) && !ARESET && (|req_valid);
  assign grant_idx = grant[1];

  amdc_rr_arb2 u_rr_arb (
    .clk    (ACLK),
    .reset  (ARESET),
    .req    (req_valid),
    .advance(arb_take),
    .grant  (grant)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      cur_port  <= 1'b0;
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cap_data  <= '0;
    end else begin
      state <= state_next;
      if (arb_take) begin
        cur_port  <= grant_idx;
        cur_write <= req_write[grant_idx];
        cur_addr  <= grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        cur_wdata <= grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      end
      if (state == CAPTURE) begin
        cap_data <= reg_rdata;
      end
    end
  end

  // Outputs are forced quiet while reset is held, even before the state register clears.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    rsp_rdata  = '0;
    reg_wr     = 1'b0;
    reg_rd     = 1'b0;
    reg_addr   = '0;
    reg_wdata  = '0;
    if (!ARESET) begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            req_ready  = grant;
            state_next = ISSUE;
          end
        end
        ISSUE: begin
          reg_wr     = cur_write;
          reg_rd     = !cur_write;
          reg_addr   = cur_addr;
          reg_wdata  = cur_wdata;
          state_next = cur_write ? RESP : CAPTURE;
        end
        CAPTURE: begin
          state_next = RESP;
        end
        RESP: begin
          rsp_valid[cur_port] = 1'b1;
          rsp_rdata           = cur_write ? '0 : cap_data;
          state_next          = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule
